// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Registers: DATA at BASE_ADDR, STATUS at BASE_ADDR+1, CTRL at BASE_ADDR+2.
// Optional interrupt output enabled by defining UART_TX_IRQ_EN.
module io_uart_tx #(
  parameter logic [15:0] BASE_ADDR = 16'h0080,
  parameter int unsigned CLK_DIV   = 1250,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic [15:0] w_addr,
  input  logic        w_en,
  input  logic [15:0] r_addr,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] CTRL_ADDR   = BASE_ADDR + 16'd2;
  localparam logic [15:0] BAUD_LAST   = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [7:0]         dout_q, dout_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         mem_q [DEPTH];

  logic [FIFO_AW:0]   count;
  logic               full, empty, busy, pop, push, flush, baud_done;
  logic               wr_data_hit, wr_status_hit, wr_ctrl_hit;
  logic               ctrl_irq_bit;

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign irq          = irq_q;
  assign ctrl_irq_bit = irq_en_q;
`else
  assign ctrl_irq_bit = 1'b0;
`endif

  assign wr_data_hit   = w_en && (w_addr == BASE_ADDR);
  assign wr_status_hit = w_en && (w_addr == STATUS_ADDR);
  assign wr_ctrl_hit   = w_en && (w_addr == CTRL_ADDR);

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (FIFO_AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state_q != S_IDLE) || !empty;
  assign pop       = (state_q == S_IDLE) && !empty && tx_en_q;
  assign push      = wr_data_hit && (!full || pop);
  assign flush     = wr_ctrl_hit && din[1];
  assign baud_done = (cnt_q == BAUD_LAST);

  assign tx   = tx_q;
  assign dout = dout_q;

  // Next-state for FIFO pointers, control/status bits and the read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
    // Flush drops everything still queued; a byte popped this cycle is already in the shifter.
    if (flush) rd_ptr_d = wr_ptr_d;
    ovf_d = ovf_q;
    if (wr_status_hit) ovf_d = 1'b0;
    if (wr_data_hit && !push) ovf_d = 1'b1;
    tx_en_d = tx_en_q;
    if (wr_ctrl_hit) tx_en_d = din[0];
`ifdef UART_TX_IRQ_EN
    irq_en_d = irq_en_q;
    if (wr_ctrl_hit) irq_en_d = din[2];
`endif
    dout_d = dout_q;
    if (r_en) begin
      if (r_addr == STATUS_ADDR)    dout_d = {4'b0, ovf_q, busy, empty, full};
      else if (r_addr == CTRL_ADDR) dout_d = {5'b0, ctrl_irq_bit, 1'b0, tx_en_q};
      else                          dout_d = 8'h00;
    end
  end

  // Serialiser next-state: frame sequencing, baud counter and tx level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase
    // tx is registered from the next state so the line is glitch-free.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
`ifdef UART_TX_IRQ_EN
    irq_d = irq_en_d && (wr_ptr_d == rd_ptr_d) && (state_d == S_IDLE);
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      dout_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      tx_en_q  <= 1'b1;
`ifdef UART_TX_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      dout_q   <= dout_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      tx_en_q  <= tx_en_d;
`ifdef UART_TX_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: directed register tests plus random
// bursts, with a line monitor decoding 8N1 frames compared to a byte queue.
module tb_io_uart_tx;
  localparam int unsigned DIV = 4;
  localparam logic [15:0] A_DATA = 16'h0080;
  localparam logic [15:0] A_ST   = 16'h0081;
  localparam logic [15:0] A_CTRL = 16'h0082;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] w_addr = '0;
  logic [15:0] r_addr = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [7:0]  dout;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  io_uart_tx #(.BASE_ADDR(16'h0080), .CLK_DIV(DIV), .FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .w_addr(w_addr), .w_en(w_en),
    .r_addr(r_addr), .r_en(r_en), .dout(dout), .tx(tx)
`ifdef UART_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  rx_q[$];
  logic        rx_ok_q[$];
  int unsigned rx_start_q[$];
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples each bit one cycle into its period.
  initial begin : mon
    logic [7:0]  b;
    logic        ok;
    int unsigned st;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        rx_q.push_back(b);
        rx_ok_q.push_back(ok);
        rx_start_q.push_back(st);
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    w_addr = a; din = d; w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    r_addr = a; r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    d = dout;
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_ok_q.delete(); rx_start_q.delete(); exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      rd(A_ST, s);
      n++;
    end while ((s[2] || !s[1]) && n < 3000);
    check({tag, "_idle_in_time"}, 32'(n < 3000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_nframes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_framing%0d", tag, i), 32'(rx_ok_q[i]), 32'd1);
    end
    clear_rx();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  r;
    logic [7:0]  v;
    int unsigned t0;
    int          n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_dout", 32'(dout), 32'h00);
    rst_n = 1'b1;
    rd(A_ST, r);   check("rst_status", 32'(r), 32'h02);
    rd(A_CTRL, r); check("rst_ctrl", 32'(r), 32'h01);

    // Reset mid-frame: line idles at once and queued bytes vanish
    wr(A_DATA, 8'hC3);
    wr(A_DATA, 8'h81);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_dout", 32'(dout), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(A_ST, r); check("midrst_status", 32'(r), 32'h02);
    repeat (60) @(negedge clk);
    clear_rx();
    repeat (60) @(negedge clk);
    check("midrst_discard", 32'(rx_q.size()), 32'd0);

    // Single byte and first-bit latency
    wr(A_DATA, 8'h55);
    check("lat_before", 32'(tx), 32'd1);
    @(posedge clk); #1;
    check("lat_fall", 32'(tx), 32'd0);
    exp_q.push_back(8'h55);
    wait_idle("single");
    check_frames("single");
    rd(A_ST, r); check("single_status", 32'(r), 32'h02);

    // FIFO full and overflow
    wr(A_CTRL, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      wr(A_DATA, 8'(i));
      if (i <= 8) exp_q.push_back(8'(i));
    end
    rd(A_ST, r);   check("ovf_status", 32'(r), 32'h0D);
    wr(A_ST, 8'h00);
    rd(A_ST, r);   check("ovf_cleared", 32'(r), 32'h05);
    rd(A_CTRL, r); check("ovf_ctrl", 32'(r), 32'h00);
    wr(A_CTRL, 8'h01);
    wait_idle("ovf");
    check_frames("ovf");
    rd(A_ST, r); check("ovf_final", 32'(r), 32'h02);

    // Back-to-back frames
    wr(A_DATA, 8'hA5);
    t0 = cyc;
    wr(A_DATA, 8'h3C);
    n = 0;
    do begin
      rd(A_ST, r);
      n++;
    end while (r[2] && n < 200);
    check("b2b_busy_len", cyc - t0, 32'd83);
    repeat (8) @(negedge clk);
    if (rx_start_q.size() >= 2)
      check("b2b_gap", rx_start_q[1] - rx_start_q[0], 32'd41);
    else
      check("b2b_gap_frames", 32'(rx_start_q.size()), 32'd2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check_frames("b2b");

    // Flush during first frame
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      if (i == 0) exp_q.push_back(v);
      wr(A_DATA, v);
    end
    repeat (8) @(negedge clk);
    wr(A_CTRL, 8'h03);
    wait_idle("flush");
    repeat (60) @(negedge clk);
    check_frames("flush");
    rd(A_ST, r);   check("flush_status", 32'(r), 32'h02);
    rd(A_CTRL, r); check("flush_ctrl", 32'(r), 32'h01);

    // Bus decode and read-hold
    @(negedge clk);
    r_addr = 16'h0081; r_en = 1'b0;
    @(posedge clk); #1;
    check("rd_hold", 32'(dout), 32'h01);
    rd(16'h0083, r); check("rd_unmapped", 32'(r), 32'h00);
    rd(A_CTRL, r);
    rd(A_DATA, r);   check("rd_data", 32'(r), 32'h00);
    wr(A_CTRL, 8'h00);
    wr(16'h007F, 8'hEE);
    wr(16'h0083, 8'hEF);
    rd(A_ST, r); check("wr_unmapped_status", 32'(r), 32'h02);
    wr(A_CTRL, 8'h01);
    repeat (60) @(negedge clk);
    check("wr_unmapped_noframe", 32'(rx_q.size()), 32'd0);

`ifdef UART_TX_IRQ_EN
    wr(A_CTRL, 8'h05);
    rd(A_CTRL, r); check("irq_ctrl", 32'(r), 32'h05);
    repeat (2) @(negedge clk);
    check("irq_idle", 32'(irq), 32'd1);
    wr(A_DATA, 8'h5A);
    @(posedge clk); #1;
    check("irq_push_drop", 32'(irq), 32'd0);
    exp_q.push_back(8'h5A);
    wait_idle("irq");
    check_frames("irq");
    check("irq_back", 32'(irq), 32'd1);
    wr(A_CTRL, 8'h01);
    @(posedge clk); #1;
    check("irq_disable", 32'(irq), 32'd0);
`else
    wr(A_CTRL, 8'h05);
    rd(A_CTRL, r); check("ctrl_bit2_ignored", 32'(r), 32'h01);
`endif

    // Random bursts that never exceed FIFO depth
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        wr(A_DATA, v);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle($sformatf("rand%0d", k));
      check_frames($sformatf("rand%0d", k));
      rd(A_ST, r); check($sformatf("rand%0d_status", k), 32'(r), 32'h02);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
